// File: rtl/pong_game_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pong_game_ctrl_pkg                                                         |
// | Shared definitions for the Pong game-flow controller, the graphics block   |
// | and the text overlay: game-state encoding, default frame-tick position     |
// | and a saturating counter helper.                                           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package pong_game_ctrl_pkg;

   // Encoding is visible on the game_state port, so the values are fixed.
   typedef enum logic [1:0] {
      ST_NEWGAME = 2'd0,
      ST_SERVE   = 2'd1,
      ST_PLAY    = 2'd2,
      ST_OVER    = 2'd3
   } game_state_e;

   // Frame tick lands at the start of vertical retrace.
   localparam int TICK_X_DEF = 0;
   localparam int TICK_Y_DEF = 481;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pong_frame_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pong_frame_tick                                                            |
// | Produces one clk-wide pulse per video frame by edge-detecting the match    |
// | of the scan position against (TICK_X, TICK_Y). The pixel position holds    |
// | for several clk cycles, so a plain compare would fire repeatedly.          |
// | Ports: clk, reset (sync, active-high), x/y scan position in,               |
// |        frame_tick out (single-cycle pulse).                                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module pong_frame_tick
   import pong_game_ctrl_pkg::*;
#(
   parameter int TICK_X = TICK_X_DEF,
   parameter int TICK_Y = TICK_Y_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] x,
   input  logic [9:0] y,
   output logic       frame_tick
);

   logic cond;
   logic cond_prev_d;
   logic cond_prev_q;

   assign cond = (x == 10'(TICK_X)) && (y == 10'(TICK_Y));

   always_comb begin
      cond_prev_d = cond;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cond_prev_q <= 1'b0;
      end else begin
         cond_prev_q <= cond_prev_d;
      end
   end

   assign frame_tick = cond & ~cond_prev_q;

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pong_game_ctrl                                                             |
// | Game-flow controller: sequences the graphics block through new-game,       |
// | serve, play and game-over by driving gra_still, and keeps scores, the      |
// | rally count and the winner for the score overlay.                          |
// | Ports: clk, reset (sync, active-high)                                      |
// |        btn[3:0]   debounced buttons (level)                               |
// |        x/y[9:0]   scan position for the frame tick                        |
// |        hit[1:0]   paddle hit pulses (0 = left, 1 = right)                 |
// |        miss       ball out of bounds (may last several cycles)            |
// |        gra_still, game_state, score_l, score_r, winner, rally,            |
// |        point_pulse: registered outputs                                    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module pong_game_ctrl
   import pong_game_ctrl_pkg::*;
#(
   parameter int WIN_SCORE    = 7,
   parameter int SERVE_FRAMES = 120,
   parameter int TICK_X       = TICK_X_DEF,
   parameter int TICK_Y       = TICK_Y_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] btn,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic [1:0] hit,
   input  logic       miss,
   output logic       gra_still,
   output logic [1:0] game_state,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic       winner,
   output logic [7:0] rally,
   output logic       point_pulse
);

   localparam logic [3:0] c_win_score  = 4'(WIN_SCORE);
   localparam logic [7:0] c_serve_last = 8'(SERVE_FRAMES - 1);

   game_state_e state_d, state_q;
   logic [7:0]  serve_cnt_d, serve_cnt_q;
   logic [3:0]  score_l_d, score_l_q;
   logic [3:0]  score_r_d, score_r_q;
   logic [7:0]  rally_d, rally_q;
   logic        winner_d, winner_q;
   logic        dir_d, dir_q;
   logic        gra_still_d, gra_still_q;
   logic        point_pulse_d, point_pulse_q;
   logic        btn_prev_d, btn_prev_q;

   logic        frame_tick;
   logic        btn_any;
   logic        press;
   logic [3:0]  scored_new;

   pong_frame_tick #(
      .TICK_X (TICK_X),
      .TICK_Y (TICK_Y)
   ) u_frame_tick (
      .clk        (clk),
      .reset      (reset),
      .x          (x),
      .y          (y),
      .frame_tick (frame_tick)
   );

   assign btn_any = |btn;
   assign press   = btn_any & ~btn_prev_q;

   // The player the ball was travelling away from scores: dir = 1 means the
   // ball was heading right, so the right player missed and left scores.
   assign scored_new = dir_q ? (score_l_q + 4'd1) : (score_r_q + 4'd1);

   always_comb begin
      state_d       = state_q;
      serve_cnt_d   = serve_cnt_q;
      score_l_d     = score_l_q;
      score_r_d     = score_r_q;
      rally_d       = rally_q;
      winner_d      = winner_q;
      dir_d         = dir_q;
      point_pulse_d = 1'b0;
      btn_prev_d    = btn_any;

      case (state_q)
         ST_NEWGAME: begin
            score_l_d = 4'd0;
            score_r_d = 4'd0;
            rally_d   = 8'd0;
            dir_d     = 1'b0;
            if (press) begin
               state_d     = ST_SERVE;
               serve_cnt_d = 8'd0;
            end
         end
         ST_SERVE: begin
            if (frame_tick) begin
               if (serve_cnt_q == c_serve_last) begin
                  state_d = ST_PLAY;
                  rally_d = 8'd0;
                  // The graphics block always serves leftward.
                  dir_d   = 1'b0;
               end else begin
                  serve_cnt_d = serve_cnt_q + 8'd1;
               end
            end
         end
         ST_PLAY: begin
            // Leaving PLAY on the first miss cycle makes any trailing miss
            // cycles fall outside PLAY, where they are ignored.
            if (miss) begin
               point_pulse_d = 1'b1;
               if (dir_q) begin
                  score_l_d = scored_new;
               end else begin
                  score_r_d = scored_new;
               end
               if (scored_new == c_win_score) begin
                  state_d  = ST_OVER;
                  winner_d = ~dir_q;
               end else begin
                  state_d     = ST_SERVE;
                  serve_cnt_d = 8'd0;
               end
            end else if (hit != 2'b00) begin
               rally_d = sat_inc8(rally_q);
               if (hit[0]) begin
                  dir_d = 1'b1;
               end
               if (hit[1]) begin
                  dir_d = 1'b0;
               end
            end
         end
         ST_OVER: begin
            if (press) begin
               state_d   = ST_NEWGAME;
               score_l_d = 4'd0;
               score_r_d = 4'd0;
               rally_d   = 8'd0;
               winner_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_NEWGAME;
         end
      endcase

      // Registered from the next state so it moves together with game_state.
      gra_still_d = (state_d != ST_PLAY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_NEWGAME;
         serve_cnt_q   <= 8'd0;
         score_l_q     <= 4'd0;
         score_r_q     <= 4'd0;
         rally_q       <= 8'd0;
         winner_q      <= 1'b0;
         dir_q         <= 1'b0;
         gra_still_q   <= 1'b1;
         point_pulse_q <= 1'b0;
         btn_prev_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         serve_cnt_q   <= serve_cnt_d;
         score_l_q     <= score_l_d;
         score_r_q     <= score_r_d;
         rally_q       <= rally_d;
         winner_q      <= winner_d;
         dir_q         <= dir_d;
         gra_still_q   <= gra_still_d;
         point_pulse_q <= point_pulse_d;
         btn_prev_q    <= btn_prev_d;
      end
   end

   assign gra_still   = gra_still_q;
   assign game_state  = state_q;
   assign score_l     = score_l_q;
   assign score_r     = score_r_q;
   assign winner      = winner_q;
   assign rally       = rally_q;
   assign point_pulse = point_pulse_q;

endmodule
`default_nettype wire
